// File: rtl/uart_status_sender.sv
// rtl/uart_status_sender.sv - UART frame sender for a sync byte, timestamp, status flags and XOR checksum
module uart_status_sender #(
    parameter int CLK_DIV    = 868,
    parameter int TIME_BYTES = 4,
    parameter int NUM_CH     = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*TIME_BYTES-1:0] time_value,
    input  logic [NUM_CH-1:0]       status,
    input  logic                    send_req,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [2:0]  STATUS_IDX = 3'(TIME_BYTES + 1);
    localparam logic [2:0]  LAST_IDX   = 3'(TIME_BYTES + 2);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    // The stop bit spends its final cycle in NEXT, so STOP itself ends one cycle early.
    localparam logic [15:0] STOP_LAST  = 16'(CLK_DIV - 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, NEXT} state_t;

    state_t                  state;
    logic [15:0]             div_cnt;
    logic [2:0]              bit_cnt;
    logic [2:0]              byte_idx;
    logic [7:0]              shreg;
    logic                    par_bit;
    logic [7:0]              csum;
    logic [8*TIME_BYTES-1:0] time_snap;
    logic [NUM_CH-1:0]       status_snap;
    logic [7:0]              status_byte;
    logic [7:0]              next_byte;
    logic [2:0]              next_idx;
    logic                    div_end;

    assign div_end = (div_cnt == DIV_LAST);

    // Status flags zero-extended into a byte, channel 0 in bit 0.
    always_comb begin
        status_byte = '0;
        status_byte[NUM_CH-1:0] = status_snap;
    end

    // Byte following the current one: timestamp MSB first, then status, then running checksum.
    always_comb begin
        next_idx  = byte_idx + 3'd1;
        next_byte = csum;
        if (next_idx == STATUS_IDX) begin
            next_byte = status_byte;
        end
        for (int k = 0; k < TIME_BYTES; k++) begin
            if (next_idx == 3'(k + 1)) begin
                next_byte = time_snap[8*(TIME_BYTES-1-k) +: 8];
            end
        end
    end

    // Frame sequencer: bit timing, byte selection, snapshot and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            csum        <= '0;
            time_snap   <= '0;
            status_snap <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_req) begin
                        time_snap   <= time_value;
                        status_snap <= status;
                        shreg       <= SYNC_BYTE;
                        par_bit     <= ^SYNC_BYTE;
                        csum        <= SYNC_BYTE;
                        byte_idx    <= '0;
                        div_cnt     <= '0;
                        tx          <= 1'b0;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (div_cnt == STOP_LAST) begin
                        div_cnt <= '0;
                        state   <= NEXT;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                NEXT: begin
                    if (byte_idx != LAST_IDX) begin
                        byte_idx <= next_idx;
                        shreg    <= next_byte;
                        par_bit  <= ^next_byte;
                        csum     <= csum ^ next_byte;
                        div_cnt  <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end else begin
                        done <= 1'b1;
                        // A request present as the frame closes starts the next frame with no idle bit.
                        if (send_req) begin
                            time_snap   <= time_value;
                            status_snap <= status;
                            shreg       <= SYNC_BYTE;
                            par_bit     <= ^SYNC_BYTE;
                            csum        <= SYNC_BYTE;
                            byte_idx    <= '0;
                            div_cnt     <= '0;
                            tx          <= 1'b0;
                            state       <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
